// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_pkg
// Brief    : Shared widths, memory map constants and types for the 6502 system.
// Revision : 1.0
// ============================================================================
package cpu_mem_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;
  localparam int MEM_DEPTH  = 4096;

  // Program load address; must stay below MEM_DEPTH.
  localparam logic [ADDR_WIDTH-1:0] INSTRUCTION_BASE = 16'h0200;

  typedef logic [REG_WIDTH-1:0] register_t;

  function automatic int mem_index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mem.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem
// Brief    : Byte RAM for the 6502 bus; combinational read, clocked write,
//            async clear. CPU_MEM_DEBUG_PORTS_EN adds bulk-load/monitor ports.
// Revision : 1.0
// ============================================================================
module cpu_mem #(
  parameter int DEPTH      = cpu_mem_pkg::MEM_DEPTH,
  parameter int ADDR_WIDTH = cpu_mem_pkg::ADDR_WIDTH,
  parameter int WIDTH      = cpu_mem_pkg::REG_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [WIDTH-1:0]       din,
  input  logic [ADDR_WIDTH-1:0]  addr,
  output logic [WIDTH-1:0]       dout
`ifdef CPU_MEM_DEBUG_PORTS_EN
  ,
  input  logic                   override_mem,
  input  logic [DEPTH*WIDTH-1:0] mem_override_in,
  output logic [DEPTH*WIDTH-1:0] mem_monitor
`endif
);
  import cpu_mem_pkg::*;

  localparam int c_IDX_W = mem_index_width(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_IDX_W-1:0] w_index;

  // Upper address bits alias onto the same locations.
  assign w_index = addr[c_IDX_W-1:0];

  generate
    if (ADDR_WIDTH > c_IDX_W) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^addr[ADDR_WIDTH-1:c_IDX_W];
    end
  endgenerate

`ifdef CPU_MEM_DEBUG_PORTS_EN
  logic [WIDTH-1:0] w_image [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign w_image[gi]                     = mem_override_in[gi*WIDTH +: WIDTH];
      assign mem_monitor[gi*WIDTH +: WIDTH]  = r_mem[gi];
    end
  endgenerate
`endif

  // Priority: reset, then bulk load, then the single CPU write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end
`ifdef CPU_MEM_DEBUG_PORTS_EN
    else if (override_mem) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_image[i];
      end
    end
`endif
    else if (we) begin
      r_mem[w_index] <= din;
    end
  end

  assign dout = r_mem[w_index];

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem
// Brief    : Self-checking bench for cpu_mem (table vectors, corner sequences,
//            randomized ops against an array model).
// Revision : 1.0
// ============================================================================
module tb_cpu_mem;
  import cpu_mem_pkg::*;

  localparam int DEPTH = MEM_DEPTH;
  localparam int AW    = 16;
  localparam int W     = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          we    = 1'b0;
  logic [W-1:0]  din   = '0;
  logic [AW-1:0] addr  = '0;
  logic [W-1:0]  dout;
`ifdef CPU_MEM_DEBUG_PORTS_EN
  logic               override_mem    = 1'b0;
  logic [DEPTH*W-1:0] mem_override_in = '0;
  logic [DEPTH*W-1:0] mem_monitor;
`endif

  cpu_mem #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .we              (we),
    .din             (din),
    .addr            (addr),
    .dout            (dout)
`ifdef CPU_MEM_DEBUG_PORTS_EN
    ,
    .override_mem    (override_mem),
    .mem_override_in (mem_override_in),
    .mem_monitor     (mem_monitor)
`endif
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] model [DEPTH];

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddr;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic read_check(input string name, input logic [AW-1:0] a);
    addr = a;
    #1;
    check(name, dout, model[idx(a)]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef CPU_MEM_DEBUG_PORTS_EN
  task automatic check_monitor(input string name);
    int bad;
    bad = -1;
    n_tests++;
    for (int i = 0; i < DEPTH; i++)
      if (bad < 0 && mem_monitor[i*W +: W] !== model[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: byte %0d got %02h expected %02h", name, bad,
               mem_monitor[bad*W +: W], model[bad]);
    end
  endtask
`endif

  initial begin
    // Reset state, no clock edge involved.
    #2 reset = 1'b1;
    #1;
    check("reset_initial", dout, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Preload 0xAA, then confirm reset clears immediately.
`ifdef CPU_MEM_DEBUG_PORTS_EN
    mem_override_in = {DEPTH{8'hAA}};
    override_mem = 1'b1;
    tick();
    override_mem = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'hAA;
`endif
    we = 1'b1; din = 8'hAA; addr = 16'h0000; tick();
    addr = 16'h0FFF; tick();
    we = 1'b0;
    model[0] = 8'hAA; model[DEPTH-1] = 8'hAA;
    read_check("preload_fff", 16'h0FFF);
    addr = 16'h0000;
    reset = 1'b1;
    #1;
    check("reset_async_000", dout, 8'h00);
    addr = 16'h0FFF;
    #1;
    check("reset_async_fff", dout, 8'h00);
    model_reset();
`ifdef CPU_MEM_DEBUG_PORTS_EN
    check_monitor("reset_monitor");
`endif
    tick();
    reset = 1'b0;

    // Table-driven write/read vectors.
    vecs[0] = '{1'b1, 16'h0010, 8'h5C, 16'h0010, 8'h5C};
    vecs[1] = '{1'b0, 16'h0011, 8'h33, 16'h0011, 8'h00};
    vecs[2] = '{1'b1, 16'h1005, 8'h77, 16'h0005, 8'h77};
    vecs[3] = '{1'b1, 16'hF0FF, 8'h3C, 16'h00FF, 8'h3C};
    vecs[4] = '{1'b0, 16'h0010, 8'h11, 16'h0010, 8'h5C};
    vecs[5] = '{1'b1, 16'h0011, 8'hA5, 16'h0010, 8'h5C};
    vecs[6] = '{1'b0, 16'h0000, 8'h00, 16'h0011, 8'hA5};
    for (int v = 0; v < 7; v++) begin
      we = vecs[v].we; addr = vecs[v].waddr; din = vecs[v].wdata;
      tick();
      if (vecs[v].we) model[idx(vecs[v].waddr)] = vecs[v].wdata;
      we = 1'b0; addr = vecs[v].raddr;
      #1;
      check($sformatf("vec%0d", v), dout, vecs[v].exp);
    end
`ifdef CPU_MEM_DEBUG_PORTS_EN
    check("wrap_monitor_b5", mem_monitor[5*W +: W], 8'h77);
`endif

    // Read-during-write: old data before the edge, new data after.
    we = 1'b1; addr = 16'h0040; din = 8'h12;
    #1;
    check("rdw_before", dout, 8'h00);
    tick();
    check("rdw_after", dout, 8'h12);
    we = 1'b0;
    model[16'h40] = 8'h12;

`ifdef CPU_MEM_DEBUG_PORTS_EN
    // Override beats a same-edge CPU write.
    for (int i = 0; i < DEPTH; i++) mem_override_in[i*W +: W] = i[7:0];
    override_mem = 1'b1; we = 1'b1; addr = 16'h0003; din = 8'hEE;
    tick();
    override_mem = 1'b0; we = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = i[7:0];
    read_check("ovr_0ff", 16'h00FF);
    check("ovr_0ff_const", dout, 8'hFF);
    read_check("ovr_100", 16'h0100);
    check("ovr_100_const", dout, 8'h00);
    read_check("ovr_prio_003", 16'h0003);
    check("ovr_prio_const", dout, 8'h03);
    check_monitor("ovr_monitor");

    // Held override reloads on every edge.
    override_mem = 1'b1;
    tick();
    mem_override_in[7*W +: W] = 8'h5A;
    tick();
    override_mem = 1'b0;
    model[7] = 8'h5A;
    read_check("ovr_hold_reload", 16'h0007);
`endif

    // Async read sweep within one clock phase.
    tick();
    for (int i = 0; i < 16; i++) read_check($sformatf("sweep_%0d", i), 16'(i));

    // Randomized operations against the model.
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [AW-1:0] ra;
      op = $urandom_range(0, 19);
      we = (op < 12);
      addr = 16'($urandom);
      din = 8'($urandom);
`ifdef CPU_MEM_DEBUG_PORTS_EN
      if (op == 19) begin
        for (int i = 0; i < DEPTH; i++) mem_override_in[i*W +: W] = 8'($urandom);
        override_mem = 1'b1;
      end
`endif
      tick();
`ifdef CPU_MEM_DEBUG_PORTS_EN
      if (override_mem) begin
        for (int i = 0; i < DEPTH; i++) model[i] = mem_override_in[i*W +: W];
      end else
`endif
      if (we) model[idx(addr)] = din;
`ifdef CPU_MEM_DEBUG_PORTS_EN
      override_mem = 1'b0;
`endif
      we = 1'b0;
      ra = ($urandom_range(0, 1) == 0) ? addr : 16'($urandom);
      read_check("rand", ra);
    end
`ifdef CPU_MEM_DEBUG_PORTS_EN
    check_monitor("rand_monitor");
`endif

    // Reset mid-cycle with a write pending: write is lost, array cleared.
    tick();
    we = 1'b1; addr = 16'h0020; din = 8'h99;
`ifdef CPU_MEM_DEBUG_PORTS_EN
    mem_override_in = {DEPTH{8'h6B}};
    override_mem = 1'b1;
`endif
    #4 reset = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
`ifdef CPU_MEM_DEBUG_PORTS_EN
    override_mem = 1'b0;
`endif
    #1 reset = 1'b0;
    model_reset();
    read_check("midreset_020", 16'h0020);
    check("midreset_020_const", dout, 8'h00);
    read_check("midreset_010", 16'h0010);
`ifdef CPU_MEM_DEBUG_PORTS_EN
    check_monitor("midreset_monitor");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
